fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 133 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and hazard scoreboard for the X stage, with a single outstanding multdiv tracker.
// Optional stall counter output is enabled by defining FWD_STALL_CNT_EN.
module fwd_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int MD_MAX_CYC = 40
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              x_src_a_en,
    input  logic              x_src_b_en,
    input  logic [ADDR_W-1:0] x_src_a,
    input  logic [ADDR_W-1:0] x_src_b,
    input  logic [DATA_W-1:0] x_a_in,
    input  logic [DATA_W-1:0] x_b_in,
    input  logic              m_wr_en,
    input  logic [ADDR_W-1:0] m_wr_rd,
    input  logic [DATA_W-1:0] m_wr_data,
    input  logic              m_is_load,
    input  logic              w_wr_en,
    input  logic [ADDR_W-1:0] w_wr_rd,
    input  logic [DATA_W-1:0] w_wr_data,
    input  logic              md_start,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic              md_done,
    input  logic [DATA_W-1:0] md_result,
    output logic [DATA_W-1:0] x_a_out,
    output logic [DATA_W-1:0] x_b_out,
    output logic              stall,
    output logic              md_busy,
    output logic              md_timeout
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [7:0] CNT_LAST = 8'(MD_MAX_CYC - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                         state, state_nxt;
    logic [ADDR_W-1:0]              pend_rd, pend_rd_nxt;
    logic [7:0]                     cnt, cnt_nxt;
    logic [1:0]                     src_en;
    logic [1:0][ADDR_W-1:0]         src;
    logic [1:0][DATA_W-1:0]         opnd_in, opnd_out;
    logic [1:0]                     load_hit, md_hit;

    assign md_busy = (state == BUSY);

    always_comb begin
        state_nxt   = state;
        pend_rd_nxt = pend_rd;
        cnt_nxt     = cnt;
        md_timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_nxt   = BUSY;
                    pend_rd_nxt = md_rd;
                    cnt_nxt     = '0;
                end
            end
            BUSY: begin
                if (md_done) begin
                    // A same-cycle issue hands the tracker straight to the new op
                    if (md_start) begin
                        pend_rd_nxt = md_rd;
                        cnt_nxt     = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    md_timeout = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pend_rd <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            pend_rd <= pend_rd_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign src_en  = {x_src_b_en, x_src_a_en};
    assign src     = {x_src_b, x_src_a};
    assign opnd_in = {x_b_in, x_a_in};

    // Reset gates all forwarding so the DX operands pass through untouched
    always_comb begin
        opnd_out = opnd_in;
        load_hit = '0;
        md_hit   = '0;
        for (int i = 0; i < 2; i++) begin
            if (reset_n && src_en[i] && src[i] != '0) begin
                if (md_busy && md_done && src[i] == pend_rd)
                    opnd_out[i] = md_result;
                else if (m_wr_en && !m_is_load && src[i] == m_wr_rd)
                    opnd_out[i] = m_wr_data;
                else if (w_wr_en && src[i] == w_wr_rd)
                    opnd_out[i] = w_wr_data;
                load_hit[i] = m_wr_en && m_is_load && (src[i] == m_wr_rd);
                md_hit[i]   = md_busy && !md_done && (src[i] == pend_rd);
            end
        end
    end

    assign x_a_out = opnd_out[0];
    assign x_b_out = opnd_out[1];
    assign stall   = (|load_hit) || ((|md_hit) && !md_timeout);

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed scoreboard bench for fwd_scoreboard: the driver queues expected outputs, a negedge monitor checks them.
module tb_fwd_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          x_src_a_en, x_src_b_en;
    logic [AW-1:0] x_src_a, x_src_b;
    logic [DW-1:0] x_a_in, x_b_in;
    logic          m_wr_en, m_is_load;
    logic [AW-1:0] m_wr_rd;
    logic [DW-1:0] m_wr_data;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_rd;
    logic [DW-1:0] w_wr_data;
    logic          md_start, md_done;
    logic [AW-1:0] md_rd;
    logic [DW-1:0] md_result;
    logic [DW-1:0] x_a_out, x_b_out;
    logic          stall, md_busy, md_timeout;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    fwd_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .MD_MAX_CYC(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .x_src_a_en(x_src_a_en), .x_src_b_en(x_src_b_en),
        .x_src_a(x_src_a), .x_src_b(x_src_b),
        .x_a_in(x_a_in), .x_b_in(x_b_in),
        .m_wr_en(m_wr_en), .m_wr_rd(m_wr_rd), .m_wr_data(m_wr_data), .m_is_load(m_is_load),
        .w_wr_en(w_wr_en), .w_wr_rd(w_wr_rd), .w_wr_data(w_wr_data),
        .md_start(md_start), .md_rd(md_rd), .md_done(md_done), .md_result(md_result),
        .x_a_out(x_a_out), .x_b_out(x_b_out), .stall(stall),
        .md_busy(md_busy), .md_timeout(md_timeout)
`ifdef FWD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] a, b, scnt;
        logic        st, bz, to;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_scnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic st, input logic bz, input logic to);
        exp_t r;
        r.name = name; r.a = a; r.b = b; r.st = st; r.bz = bz; r.to = to;
        if (!reset_n) exp_scnt = 0;
        r.scnt = exp_scnt;
        if (reset_n && st && exp_scnt != 32'hFFFF_FFFF) exp_scnt++;
        exp_q.push_back(r);
    endtask

    task automatic defaults();
        x_src_a_en = 0; x_src_b_en = 0; x_src_a = 0; x_src_b = 0;
        x_a_in = 32'hA0A0; x_b_in = 32'hB0B0;
        m_wr_en = 0; m_wr_rd = 0; m_wr_data = 0; m_is_load = 0;
        w_wr_en = 0; w_wr_rd = 0; w_wr_data = 0;
        md_start = 0; md_rd = 0; md_done = 0; md_result = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        defaults();
    endtask

    // Monitor: every negedge, drain expectations queued for the current cycle
    initial begin
        exp_t r;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk({r.name, ".a"}, x_a_out, r.a);
                chk({r.name, ".b"}, x_b_out, r.b);
                chk({r.name, ".stall"}, {31'd0, stall}, {31'd0, r.st});
                chk({r.name, ".busy"}, {31'd0, md_busy}, {31'd0, r.bz});
                chk({r.name, ".tmo"}, {31'd0, md_timeout}, {31'd0, r.to});
`ifdef FWD_STALL_CNT_EN
                chk({r.name, ".scnt"}, stall_cnt, r.scnt);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        defaults();
        // reset held: M load to the read register must neither stall nor forward
        step(); x_src_a_en = 1; x_src_a = 3; m_wr_en = 1; m_wr_rd = 3; m_wr_data = 32'h11; m_is_load = 1;
        expect_out("rst_pass", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); reset_n = 1; x_src_a_en = 1; x_src_a = 3;
        m_wr_en = 1; m_wr_rd = 3; m_wr_data = 32'h11; w_wr_en = 1; w_wr_rd = 3; w_wr_data = 32'h22;
        expect_out("m_over_w", 32'h11, 32'hB0B0, 0, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 3; w_wr_en = 1; w_wr_rd = 3; w_wr_data = 32'h22;
        expect_out("w_fwd", 32'h22, 32'hB0B0, 0, 0, 0);
        step(); x_src_b_en = 1; x_src_b = 0; m_wr_en = 1; m_wr_rd = 0; m_wr_data = 32'h5;
        expect_out("r0_nofwd", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); x_src_b_en = 1; x_src_b = 4; w_wr_en = 1; w_wr_rd = 4; w_wr_data = 32'h44;
        expect_out("b_w_fwd", 32'hA0A0, 32'h44, 0, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 7; m_wr_en = 1; m_wr_rd = 7; m_is_load = 1; m_wr_data = 32'h1;
        expect_out("load_use", 32'hA0A0, 32'hB0B0, 1, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 7; w_wr_en = 1; w_wr_rd = 7; w_wr_data = 32'h99;
        expect_out("load_in_w", 32'h99, 32'hB0B0, 0, 0, 0);
        step(); x_src_a_en = 0; x_src_a = 7; m_wr_en = 1; m_wr_rd = 7; m_is_load = 1;
        expect_out("load_noen", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        // multdiv to r9 completing normally
        step(); md_start = 1; md_rd = 9; x_src_a_en = 1; x_src_a = 9;
        expect_out("md_issue", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 9; md_start = 1; md_rd = 5;
        w_wr_en = 1; w_wr_rd = 9; w_wr_data = 32'h77;
        expect_out("md_stall1", 32'h77, 32'hB0B0, 1, 1, 0);
        step(); x_src_b_en = 1; x_src_b = 5;
        expect_out("md_ign_start", 32'hA0A0, 32'hB0B0, 0, 1, 0);
        step(); x_src_a_en = 1; x_src_a = 9; md_done = 1; md_result = 32'hABCD;
        expect_out("md_done_fwd", 32'hABCD, 32'hB0B0, 0, 1, 0);
        step(); x_src_a_en = 1; x_src_a = 9;
        expect_out("md_idle", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 9; md_done = 1; md_result = 32'h1234;
        expect_out("done_in_idle", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        // back-to-back issue, then the reissued op times out (limit 4)
        step(); md_start = 1; md_rd = 9;
        expect_out("md_issue2", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 9; x_src_b_en = 1; x_src_b = 12;
        md_done = 1; md_result = 32'h55; md_start = 1; md_rd = 12;
        expect_out("done_start", 32'h55, 32'hB0B0, 0, 1, 0);
        step(); x_src_b_en = 1; x_src_b = 12;
        expect_out("tmo_c1", 32'hA0A0, 32'hB0B0, 1, 1, 0);
        step(); x_src_b_en = 1; x_src_b = 12;
        expect_out("tmo_c2", 32'hA0A0, 32'hB0B0, 1, 1, 0);
        step(); x_src_b_en = 1; x_src_b = 12;
        expect_out("tmo_c3", 32'hA0A0, 32'hB0B0, 1, 1, 0);
        step(); x_src_b_en = 1; x_src_b = 12;
        expect_out("tmo_c4", 32'hA0A0, 32'hB0B0, 0, 1, 1);
        step(); x_src_b_en = 1; x_src_b = 12;
        expect_out("tmo_after", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        // reset while busy discards the outstanding op
        step(); md_start = 1; md_rd = 9;
        expect_out("md_issue3", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 9;
        expect_out("busy_pre_rst", 32'hA0A0, 32'hB0B0, 1, 1, 0);
        step(); reset_n = 0; x_src_a_en = 1; x_src_a = 9; m_wr_en = 1; m_wr_rd = 9; m_is_load = 1;
        expect_out("rst_busy", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); reset_n = 1; x_src_a_en = 1; x_src_a = 9; md_done = 1; md_result = 32'hDEAD;
        expect_out("done_post_rst", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        step(); x_src_a_en = 1; x_src_a = 9;
        expect_out("post_rst_idle", 32'hA0A0, 32'hB0B0, 0, 0, 0);
        @(negedge clock);
        @(posedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
